// File: rtl/pipeline_stall_controller_pkg.sv
// ============================================================================
//  pipe_ctrl_pkg
//  Shared state encoding, control-bundle type and constants for the pipeline
//  stall controller.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int          CTRL_STATE_W = 2;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_HOLD = 2'd2
    } ctrl_state_e;

    // Per-stage control bundle driven by the sequencer every cycle
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_ma_we;
        logic ma_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_ma_bubble;
        logic muldiv_go;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_PASS   = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                          ex_ma_we: 1'b1, ma_wb_we: 1'b1,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                          ex_ma_bubble: 1'b0, muldiv_go: 1'b0};
    localparam ctrl_out_t CTRL_FREEZE = '0;

    localparam int PERF_NUM   = 4;
    localparam int PERF_LOAD  = 0;
    localparam int PERF_MD    = 1;
    localparam int PERF_MEM   = 2;
    localparam int PERF_FLUSH = 3;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
//  pipeline_stall_controller_if
//  Stall request inputs and per-stage enable/flush outputs of the controller.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if;

    logic load_use_stall;
    logic muldiv_start;
    logic muldiv_done;
    logic dmem_busy;
    logic branch_taken_ex;

    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_ma_we;
    logic ma_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_ma_bubble;
    logic muldiv_go;

    modport master (
        output load_use_stall, muldiv_start, muldiv_done, dmem_busy, branch_taken_ex,
        input  pc_we, if_id_we, id_ex_we, ex_ma_we, ma_wb_we,
        input  if_id_flush, id_ex_flush, ex_ma_bubble, muldiv_go
    );

    modport slave (
        input  load_use_stall, muldiv_start, muldiv_done, dmem_busy, branch_taken_ex,
        output pc_we, if_id_we, id_ex_we, ex_ma_we, ma_wb_we,
        output if_id_flush, id_ex_flush, ex_ma_bubble, muldiv_go
    );

endinterface : pipeline_stall_controller_if

`default_nettype wire

// File: rtl/pipeline_stall_controller_stall_perf_counters.sv
// ============================================================================
//  stall_perf_counters
//  Bank of saturating event counters, one increment strobe per counter.
//  Only built when STALL_PERF_CNT_EN is defined.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef STALL_PERF_CNT_EN
module stall_perf_counters #(
    parameter int CNT_W = 32,
    parameter int NUM   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM-1:0]            i_inc,
    output logic [NUM-1:0][CNT_W-1:0] o_cnt
);

    for (genvar gi = 0; gi < NUM; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (i_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign o_cnt[gi] = r_cnt;
    end

endmodule : stall_perf_counters
`endif

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
//  pipeline_stall_controller
//  Priority-resolved enables/flushes/bubbles for the 5-stage RV32IM pipeline.
//  Optional perf counters: define STALL_PERF_CNT_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int MD_CNT_W   = 7,
    parameter int PERF_CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipeline_stall_controller_if.slave  bus,
    output logic                        md_timeout_err,
    output logic [CTRL_STATE_W-1:0]     ctrl_state,
    output logic [PERF_CNT_W-1:0]       perf_load_stalls,
    output logic [PERF_CNT_W-1:0]       perf_md_stalls,
    output logic [PERF_CNT_W-1:0]       perf_mem_stalls,
    output logic [PERF_CNT_W-1:0]       perf_flushes
);

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_nxt;
    ctrl_state_e         w_eff_state;
    logic                r_ret_md;
    logic                w_ret_md_nxt;
    logic [MD_CNT_W-1:0] r_md_cnt;
    logic [MD_CNT_W-1:0] w_md_cnt_nxt;
    logic                r_done_pend;
    logic                w_done_pend_nxt;
    logic                r_timeout_err;
    logic                w_timeout_err_nxt;
    logic                w_md_done;
    logic                w_md_expired;
    ctrl_out_t           w_ctrl;
    logic [PERF_NUM-1:0] w_perf_inc;

    // MEM_HOLD's first free cycle behaves exactly like the state it returns to
    always_comb begin
        w_eff_state = r_state;
        if (r_state == ST_MEM_HOLD) begin
            w_eff_state = r_ret_md ? ST_MD_WAIT : ST_RUN;
        end
    end

    assign w_md_done    = bus.muldiv_done | r_done_pend;
    assign w_md_expired = (r_md_cnt == MD_CNT_W'(MD_TIMEOUT));

    always_comb begin
        w_ctrl            = CTRL_PASS;
        w_state_nxt       = r_state;
        w_ret_md_nxt      = r_ret_md;
        w_md_cnt_nxt      = r_md_cnt;
        w_done_pend_nxt   = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        w_perf_inc        = '0;

        if (!rst_n) begin
            w_ctrl = CTRL_PASS;
        end else if (bus.dmem_busy) begin
            w_ctrl                 = CTRL_FREEZE;
            w_state_nxt            = ST_MEM_HOLD;
            w_ret_md_nxt           = (w_eff_state == ST_MD_WAIT);
            w_done_pend_nxt        = (w_eff_state == ST_MD_WAIT) & w_md_done;
            w_perf_inc[PERF_MEM]   = 1'b1;
        end else begin
            case (w_eff_state)
                ST_MD_WAIT: begin
                    w_perf_inc[PERF_MD] = 1'b1;
                    if (w_md_done || w_md_expired) begin
                        // Result (or abort) is captured into EX/MA this cycle
                        w_state_nxt  = ST_RUN;
                        w_md_cnt_nxt = '0;
                        if (!w_md_done) begin
                            w_timeout_err_nxt = 1'b1;
                        end
                    end else begin
                        w_ctrl.pc_we        = 1'b0;
                        w_ctrl.if_id_we     = 1'b0;
                        w_ctrl.id_ex_we     = 1'b0;
                        w_ctrl.ex_ma_bubble = 1'b1;
                        w_state_nxt         = ST_MD_WAIT;
                        w_md_cnt_nxt        = r_md_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    if (bus.muldiv_start) begin
                        w_ctrl.muldiv_go    = 1'b1;
                        w_ctrl.pc_we        = 1'b0;
                        w_ctrl.if_id_we     = 1'b0;
                        w_ctrl.id_ex_we     = 1'b0;
                        w_ctrl.ex_ma_bubble = 1'b1;
                        w_state_nxt         = ST_MD_WAIT;
                        w_md_cnt_nxt        = MD_CNT_W'(1);
                    end else if (bus.branch_taken_ex) begin
                        w_ctrl.if_id_flush     = 1'b1;
                        w_ctrl.id_ex_flush     = 1'b1;
                        w_perf_inc[PERF_FLUSH] = 1'b1;
                    end else if (bus.load_use_stall) begin
                        w_ctrl.pc_we          = 1'b0;
                        w_ctrl.if_id_we       = 1'b0;
                        w_ctrl.id_ex_flush    = 1'b1;
                        w_perf_inc[PERF_LOAD] = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_ret_md      <= 1'b0;
            r_md_cnt      <= '0;
            r_done_pend   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ret_md      <= w_ret_md_nxt;
            r_md_cnt      <= w_md_cnt_nxt;
            r_done_pend   <= w_done_pend_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.pc_we        = w_ctrl.pc_we;
    assign bus.if_id_we     = w_ctrl.if_id_we;
    assign bus.id_ex_we     = w_ctrl.id_ex_we;
    assign bus.ex_ma_we     = w_ctrl.ex_ma_we;
    assign bus.ma_wb_we     = w_ctrl.ma_wb_we;
    assign bus.if_id_flush  = w_ctrl.if_id_flush;
    assign bus.id_ex_flush  = w_ctrl.id_ex_flush;
    assign bus.ex_ma_bubble = w_ctrl.ex_ma_bubble;
    assign bus.muldiv_go    = w_ctrl.muldiv_go;

    assign md_timeout_err = r_timeout_err;
    assign ctrl_state     = r_state;

`ifdef STALL_PERF_CNT_EN
    logic [PERF_NUM-1:0][PERF_CNT_W-1:0] w_perf_cnt;

    stall_perf_counters #(
        .CNT_W (PERF_CNT_W),
        .NUM   (PERF_NUM)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_perf_inc),
        .o_cnt (w_perf_cnt)
    );

    assign perf_load_stalls = w_perf_cnt[PERF_LOAD];
    assign perf_md_stalls   = w_perf_cnt[PERF_MD];
    assign perf_mem_stalls  = w_perf_cnt[PERF_MEM];
    assign perf_flushes     = w_perf_cnt[PERF_FLUSH];
`else
    logic w_unused_perf;
    assign w_unused_perf    = ^w_perf_inc;
    assign perf_load_stalls = '0;
    assign perf_md_stalls   = '0;
    assign perf_mem_stalls  = '0;
    assign perf_flushes     = '0;
`endif

endmodule : pipeline_stall_controller

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
//  tb_pipeline_stall_controller
//  Directed-vector bench with hand-computed control bundles and states.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

    localparam int PERF_W = 32;

    // {pc, if_id, id_ex, ex_ma, ma_wb, if_id_flush, id_ex_flush, bubble, go}
    localparam logic [8:0] c_PASS   = 9'b11111_000_0;
    localparam logic [8:0] c_LU     = 9'b00111_010_0;
    localparam logic [8:0] c_START  = 9'b00011_001_1;
    localparam logic [8:0] c_WAIT   = 9'b00011_001_0;
    localparam logic [8:0] c_FREEZE = 9'b00000_000_0;
    localparam logic [8:0] c_BR     = 9'b11111_110_0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              md_timeout_err;
    logic [1:0]        ctrl_state;
    logic [PERF_W-1:0] perf_load_stalls, perf_md_stalls, perf_mem_stalls, perf_flushes;
    logic [8:0]        w_obs;
    int                n_tests = 0;
    int                n_fail  = 0;

    pipeline_stall_controller_if bus();

    pipeline_stall_controller #(
        .MD_TIMEOUT (8),
        .MD_CNT_W   (4),
        .PERF_CNT_W (PERF_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .md_timeout_err   (md_timeout_err),
        .ctrl_state       (ctrl_state),
        .perf_load_stalls (perf_load_stalls),
        .perf_md_stalls   (perf_md_stalls),
        .perf_mem_stalls  (perf_mem_stalls),
        .perf_flushes     (perf_flushes)
    );

    always #5 clk = ~clk;

    assign w_obs = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_ma_we, bus.ma_wb_we,
                    bus.if_id_flush, bus.id_ex_flush, bus.ex_ma_bubble, bus.muldiv_go};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, check outputs and state mid-cycle
    task automatic step(input logic lu, input logic st, input logic dn, input logic bz,
                        input logic br, input logic [8:0] exp_ctrl, input logic [1:0] exp_st,
                        input string tag);
        bus.load_use_stall  = lu;
        bus.muldiv_start    = st;
        bus.muldiv_done     = dn;
        bus.dmem_busy       = bz;
        bus.branch_taken_ex = br;
        @(negedge clk);
        check({tag, ".ctrl"}, {23'd0, w_obs}, {23'd0, exp_ctrl});
        check({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, exp_st});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load_use_stall = 1'b0; bus.muldiv_start = 1'b0; bus.muldiv_done = 1'b0;
        bus.dmem_busy = 1'b0; bus.branch_taken_ex = 1'b0;
        @(posedge clk); #1;

        // Reset: enables forced high regardless of requests
        step(1, 0, 0, 0, 0, c_PASS, 2'd0, "rst_lu");
        step(1, 1, 0, 1, 1, c_PASS, 2'd0, "rst_all");
        check("rst_err", {31'd0, md_timeout_err}, 32'd0);
        rst_n = 1'b1;

        // Load-use stall
        step(1, 0, 0, 0, 0, c_LU,   2'd0, "lu");
        step(0, 0, 0, 0, 0, c_PASS, 2'd0, "lu_after");

        // MUL/DIV with done five cycles after start
        step(0, 1, 0, 0, 0, c_START, 2'd0, "md_start");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, c_WAIT, 2'd1, "md_wait");
        step(0, 0, 1, 0, 0, c_PASS, 2'd1, "md_done");
        step(0, 0, 0, 0, 0, c_PASS, 2'd0, "md_run");

        // dmem_busy during MD_WAIT, done arrives while held
        step(0, 1, 0, 0, 0, c_START,  2'd0, "mh_start");
        step(0, 0, 0, 0, 0, c_WAIT,   2'd1, "mh_wait");
        step(0, 0, 0, 1, 0, c_FREEZE, 2'd1, "mh_busy1");
        step(0, 0, 1, 1, 0, c_FREEZE, 2'd2, "mh_busy2");
        step(0, 0, 0, 1, 0, c_FREEZE, 2'd2, "mh_busy3");
        step(0, 0, 0, 0, 0, c_PASS,   2'd2, "mh_release");
        step(0, 0, 0, 0, 0, c_PASS,   2'd0, "mh_run");

        // Redirect priorities
        step(1, 0, 0, 0, 1, c_BR,     2'd0, "br_lu");
        step(0, 0, 0, 0, 1, c_BR,     2'd0, "br");
        step(0, 0, 0, 1, 1, c_FREEZE, 2'd0, "busy_br");
        step(0, 0, 0, 0, 0, c_PASS,   2'd2, "hold_free");
        step(1, 0, 0, 0, 0, c_LU,     2'd0, "lu2");
        step(1, 0, 0, 0, 0, c_LU,     2'd0, "lu3");
        step(0, 1, 0, 0, 1, c_START,  2'd0, "start_br");
        step(0, 0, 1, 0, 0, c_PASS,   2'd1, "start_br_done");
        step(0, 0, 0, 0, 0, c_PASS,   2'd0, "start_br_run");

`ifdef STALL_PERF_CNT_EN
        check("perf_load",  perf_load_stalls, 32'd3);
        check("perf_flush", perf_flushes,     32'd2);
        check("perf_mem",   perf_mem_stalls,  32'd4);
`else
        check("perf_load",  perf_load_stalls, 32'd0);
        check("perf_flush", perf_flushes,     32'd0);
        check("perf_mem",   perf_mem_stalls,  32'd0);
        check("perf_md",    perf_md_stalls,   32'd0);
`endif

        // Watchdog: no done, MD_TIMEOUT = 8
        step(0, 1, 0, 0, 0, c_START, 2'd0, "to_start");
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0, 0, c_WAIT, 2'd1, "to_wait");
            check("to_err_low", {31'd0, md_timeout_err}, 32'd0);
        end
        step(0, 0, 0, 0, 0, c_PASS, 2'd1, "to_release");
        check("to_err_set", {31'd0, md_timeout_err}, 32'd1);
        step(0, 0, 0, 0, 0, c_PASS, 2'd0, "to_run");
        step(1, 0, 0, 0, 0, c_LU,   2'd0, "to_lu");
        check("to_err_sticky", {31'd0, md_timeout_err}, 32'd1);

        // Reset in the middle of MD_WAIT
        step(0, 1, 0, 0, 0, c_START, 2'd0, "rmid_start");
        step(0, 0, 0, 0, 0, c_WAIT,  2'd1, "rmid_wait");
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, c_PASS,  2'd1, "rmid_rst");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, c_PASS,  2'd0, "rmid_run");
        check("rmid_err", {31'd0, md_timeout_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_stall_controller

`default_nettype wire
